ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter CPUS, default 2: number of cache requesters, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port iREN  in  CPUS  per-CPU instruction read request.
REQ-007 SHALL have port dREN  in  CPUS  per-CPU data read request.
REQ-008 SHALL have port dWEN  in  CPUS  per-CPU data write request.
REQ-009 SHALL have port iaddr  in  CPUS*ADDR_W  per-CPU instruction address; CPU k occupies slice k.
REQ-010 SHALL have port daddr  in  CPUS*ADDR_W  per-CPU data address.
REQ-011 SHALL have port dstore  in  CPUS*DATA_W  per-CPU write data.
REQ-012 SHALL have port iwait  out  CPUS  per-CPU instruction stall.
REQ-013 SHALL have port dwait  out  CPUS  per-CPU data stall.
REQ-014 SHALL have port iload  out  CPUS*DATA_W  per-CPU instruction read data.
REQ-015 SHALL have port dload  out  CPUS*DATA_W  per-CPU data read data.
REQ-016 SHALL have port ramREN  out  1  RAM read enable.
REQ-017 SHALL have port ramWEN  out  1  RAM write enable.
REQ-018 SHALL have port ramaddr  out  ADDR_W  RAM address.
REQ-019 SHALL have port ramstore  out  DATA_W  RAM write data.
REQ-020 SHALL have port ramload  in  DATA_W  RAM read data.
REQ-021 SHALL have port ramstate  in  2  RAM status; cpu_types_pkg encoding FREE, BUSY, ACCESS, ERROR.

Function
REQ-022 SHALL run FSM states IDLE, GRANT, ERR.
REQ-023 Request sources: 2*CPUS ports; within one CPU, data (dREN or dWEN) SHALL beat instruction.
REQ-024 IDLE: if any request is pending, SHALL register the winner (CPU index, port type, read/write) and enter GRANT next cycle; ramREN/ramWEN low in IDLE.
REQ-025 GRANT: SHALL drive ramaddr/ramstore/ramREN/ramWEN from the registered winner's current inputs; dWEN drives ramWEN, dREN and iREN drive ramREN; ramaddr from daddr for data, iaddr for instruction.
REQ-026 Winner's wait SHALL drop combinationally in the cycle ramstate==ACCESS while in GRANT; the FSM then returns to IDLE.
REQ-027 All other waits SHALL be high whenever their request is asserted and not being completed; a wait with its request low SHALL be low.
REQ-028 iload/dload slice of the winner SHALL equal ramload in the completion cycle; all other slices SHALL be zero.
REQ-029 Winner deasserting its request while in GRANT SHALL abort: ram enables drop that cycle, FSM returns to IDLE, no wait released.
REQ-030 ramstate==ERROR in GRANT SHALL enter ERR; ERR holds all waits high for every asserted request and ram enables low until ramstate==FREE, then IDLE.
REQ-031 Minimum latency: request asserted in cycle N with RAM answering ACCESS at once completes in cycle N+1; back-to-back grants have one IDLE cycle between them.
REQ-032 Simultaneous dREN and dWEN on one CPU SHALL be treated as write.

Reset
REQ-033 On RST high, SHALL immediately enter IDLE, clear the winner register, set round-robin pointer to CPU 0, drive ramREN=ramWEN=0, ramaddr=ramstore=0, loads zero.
REQ-034 Reset asserted mid-GRANT SHALL drop ram enables asynchronously; requests pending at release re-arbitrate from CPU 0.

Configuration
REQ-035 With RAM_ARB_ROUND_ROBIN_EN defined, SHALL arbitrate among CPUs round-robin: the pointer advances to (winner+1) mod CPUS after each completion (not abort); search starts at the pointer.
REQ-036 Without RAM_ARB_ROUND_ROBIN_EN, SHALL use fixed priority, lowest CPU index wins; no pointer register exists.

Verification
REQ-037 CPU0 dREN daddr=0x100, RAM ACCESS at once, ramload=0xDEADBEEF -> ramREN, ramaddr=0x100 one cycle after request, dwait[0]=0, dload slice0=0xDEADBEEF that cycle.
REQ-038 CPU0 iREN and dWEN together, dstore=0x55 -> write served first (ramWEN, ramstore=0x55); instruction served next grant, iwait[0] high throughout write.
REQ-039 CPU0 and CPU1 dREN held continuously, round-robin on -> grants alternate 0,1,0,1; macro off -> CPU0 wins every grant.
REQ-040 Grant to CPU1, ramstate ERROR for 3 cycles then FREE -> ERR entered, all waits high, enables low, IDLE after FREE, request re-served.
REQ-041 RST pulsed during GRANT with ramstate BUSY -> ramREN low same cycle, all outputs at reset values, arbitration restarts at CPU 0.
REQ-042 Winner drops dREN while ramstate BUSY -> abort, no wait release, next pending CPU granted after one IDLE cycle.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU cache ports, the RAM arbiter and the RAM.
// Slices of the per-CPU vectors are indexed by CPU number.
interface ram_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*DATA_W-1:0] dstore;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*DATA_W-1:0] iload;
    logic [CPUS*DATA_W-1:0] dload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [DATA_W-1:0]      ramstore;
    logic [DATA_W-1:0]      ramload;
    logic [1:0]             ramstate;

    // arbiter side: owns the RAM bus and the stall/load returns
    modport master (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // environment side: CPU caches plus the RAM model
    modport slave (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates 2*CPUS cache ports (data beats instruction per CPU) onto one RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin across CPUs; default is fixed priority.
module ram_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    ram_arbiter_if.master bus
);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, ERR} state_t;
    typedef enum logic [1:0] {FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11} ramstate_t;

    state_t    state, state_nx;
    ramstate_t rs;

    logic [CW-1:0] win_cpu;
    logic          win_data;
    logic          win_write;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [CW-1:0] ptr;
`endif

    logic          found;
    logic [CW-1:0] sel_cpu;
    logic          sel_data;
    logic          sel_write;
    logic [CW-1:0] cidx;
    int unsigned   idx;

    logic win_active;
    logic complete;

    logic [ADDR_W-1:0] iaddr_a  [CPUS];
    logic [ADDR_W-1:0] daddr_a  [CPUS];
    logic [DATA_W-1:0] dstore_a [CPUS];
    logic [DATA_W-1:0] iload_a  [CPUS];
    logic [DATA_W-1:0] dload_a  [CPUS];

    logic [CPUS-1:0]   iwait_v, dwait_v;
    logic              ren_v, wen_v;
    logic [ADDR_W-1:0] addr_v;
    logic [DATA_W-1:0] store_v;

    for (genvar k = 0; k < CPUS; k++) begin : g_slice
        assign iaddr_a[k]  = bus.iaddr[k*ADDR_W +: ADDR_W];
        assign daddr_a[k]  = bus.daddr[k*ADDR_W +: ADDR_W];
        assign dstore_a[k] = bus.dstore[k*DATA_W +: DATA_W];
        assign bus.iload[k*DATA_W +: DATA_W] = iload_a[k];
        assign bus.dload[k*DATA_W +: DATA_W] = dload_a[k];
    end

    assign rs = ramstate_t'(bus.ramstate);

    // Search order starts at the pointer (round-robin) or CPU 0 (fixed);
    // within a CPU the data port wins and dREN+dWEN together count as a write.
    always_comb begin
        found     = 1'b0;
        sel_cpu   = '0;
        sel_data  = 1'b0;
        sel_write = 1'b0;
        idx       = 0;
        cidx      = '0;
        for (int unsigned i = 0; i < CPUS; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            idx = (32'(ptr) + i) % CPUS;
`else
            idx = i;
`endif
            cidx = CW'(idx);
            if (!found && (bus.dREN[cidx] || bus.dWEN[cidx] || bus.iREN[cidx])) begin
                found     = 1'b1;
                sel_cpu   = cidx;
                sel_data  = bus.dREN[cidx] | bus.dWEN[cidx];
                sel_write = bus.dWEN[cidx];
            end
        end
    end

    always_comb begin
        if (win_data)
            win_active = win_write ? bus.dWEN[win_cpu] : bus.dREN[win_cpu];
        else
            win_active = bus.iREN[win_cpu];
    end

    assign complete = (state == GRANT) && win_active && (rs == ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            win_cpu   <= '0;
            win_data  <= 1'b0;
            win_write <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                win_cpu   <= sel_cpu;
                win_data  <= sel_data;
                win_write <= sel_write;
            end
`ifdef RAM_ARB_ROUND_ROBIN_EN
            if (complete)
                ptr <= (win_cpu == CW'(CPUS - 1)) ? '0 : win_cpu + 1'b1;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (found) state_nx = GRANT;
            GRANT: begin
                if (!win_active || rs == ACCESS) state_nx = IDLE;
                else if (rs == ERROR)            state_nx = ERR;
            end
            ERR:   if (rs == FREE) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Waits mirror their requests except for the single port being completed.
    always_comb begin
        ren_v   = 1'b0;
        wen_v   = 1'b0;
        addr_v  = '0;
        store_v = '0;
        iwait_v = bus.iREN;
        dwait_v = bus.dREN | bus.dWEN;
        for (int unsigned k = 0; k < CPUS; k++) begin
            iload_a[k] = '0;
            dload_a[k] = '0;
        end
        if (state == GRANT) begin
            addr_v  = win_data ? daddr_a[win_cpu] : iaddr_a[win_cpu];
            store_v = dstore_a[win_cpu];
            if (win_active) begin
                wen_v = win_data & win_write;
                ren_v = ~(win_data & win_write);
            end
        end
        if (complete) begin
            if (win_data) begin
                dwait_v[win_cpu] = 1'b0;
                dload_a[win_cpu] = bus.ramload;
            end else begin
                iwait_v[win_cpu] = 1'b0;
                iload_a[win_cpu] = bus.ramload;
            end
        end
    end

    assign bus.iwait    = iwait_v;
    assign bus.dwait    = dwait_v;
    assign bus.ramREN   = ren_v;
    assign bus.ramWEN   = wen_v;
    assign bus.ramaddr  = addr_v;
    assign bus.ramstore = store_v;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (CPUS=2); expectations adapt to RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    ram_arbiter_if #(.CPUS(2), .ADDR_W(32), .DATA_W(32)) bus();

    ram_arbiter #(.CPUS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic clr;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clr;
        rst = 1'b1;
        bus.dREN = 2'b11;
        bus.ramstate = ACCESS;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL rst_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.ramWEN !== 1'b0) $display("FAIL rst_wen got=%0h exp=0", bus.ramWEN); else passes++;
        checks++; if (bus.ramaddr !== 32'h0) $display("FAIL rst_addr got=%0h exp=0", bus.ramaddr); else passes++;
        checks++; if (bus.ramstore !== 32'h0) $display("FAIL rst_store got=%0h exp=0", bus.ramstore); else passes++;
        checks++; if (bus.dload !== 64'h0) $display("FAIL rst_dload got=%0h exp=0", bus.dload); else passes++;
        checks++; if (bus.iload !== 64'h0) $display("FAIL rst_iload got=%0h exp=0", bus.iload); else passes++;
        clr;
        rst = 1'b0;
    endtask

    task automatic test_read;
        tick;
        bus.dREN = 2'b01; bus.daddr[31:0] = 32'h100;
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        settle;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL rd_idle_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.dwait !== 2'b01) $display("FAIL rd_idle_dwait got=%b exp=01", bus.dwait); else passes++;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b1) $display("FAIL rd_ren got=%0h exp=1", bus.ramREN); else passes++;
        checks++; if (bus.ramWEN !== 1'b0) $display("FAIL rd_wen got=%0h exp=0", bus.ramWEN); else passes++;
        checks++; if (bus.ramaddr !== 32'h100) $display("FAIL rd_addr got=%0h exp=100", bus.ramaddr); else passes++;
        checks++; if (bus.dwait !== 2'b00) $display("FAIL rd_dwait got=%b exp=00", bus.dwait); else passes++;
        checks++; if (bus.dload !== 64'h00000000_DEADBEEF) $display("FAIL rd_dload got=%0h exp=deadbeef", bus.dload); else passes++;
        tick;
        clr;
    endtask

    task automatic test_write_first;
        tick;
        bus.dWEN = 2'b01; bus.dREN = 2'b01; bus.iREN = 2'b01;
        bus.dstore[31:0] = 32'h55; bus.daddr[31:0] = 32'h200; bus.iaddr[31:0] = 32'h300;
        bus.ramstate = ACCESS; bus.ramload = 32'h12345678;
        settle;
        checks++; if (bus.iwait !== 2'b01) $display("FAIL wr_idle_iwait got=%b exp=01", bus.iwait); else passes++;
        checks++; if (bus.dwait !== 2'b01) $display("FAIL wr_idle_dwait got=%b exp=01", bus.dwait); else passes++;
        tick;
        settle;
        checks++; if (bus.ramWEN !== 1'b1) $display("FAIL wr_wen got=%0h exp=1", bus.ramWEN); else passes++;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL wr_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.ramstore !== 32'h55) $display("FAIL wr_store got=%0h exp=55", bus.ramstore); else passes++;
        checks++; if (bus.ramaddr !== 32'h200) $display("FAIL wr_addr got=%0h exp=200", bus.ramaddr); else passes++;
        checks++; if (bus.iwait !== 2'b01) $display("FAIL wr_iwait got=%b exp=01", bus.iwait); else passes++;
        checks++; if (bus.dwait !== 2'b00) $display("FAIL wr_dwait got=%b exp=00", bus.dwait); else passes++;
        tick;
        bus.dWEN = '0; bus.dREN = '0;
        settle;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL wr_gap_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.iwait !== 2'b01) $display("FAIL wr_gap_iwait got=%b exp=01", bus.iwait); else passes++;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b1) $display("FAIL if_ren got=%0h exp=1", bus.ramREN); else passes++;
        checks++; if (bus.ramaddr !== 32'h300) $display("FAIL if_addr got=%0h exp=300", bus.ramaddr); else passes++;
        checks++; if (bus.iwait !== 2'b00) $display("FAIL if_iwait got=%b exp=00", bus.iwait); else passes++;
        checks++; if (bus.iload !== 64'h00000000_12345678) $display("FAIL if_iload got=%0h exp=12345678", bus.iload); else passes++;
        checks++; if (bus.dload !== 64'h0) $display("FAIL if_dload got=%0h exp=0", bus.dload); else passes++;
        tick;
        clr;
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_addr;
        logic [1:0]  exp_dwait;
        tick;
        bus.dREN = 2'b11; bus.daddr = {32'h20, 32'h10}; bus.ramstate = ACCESS;
        for (int g = 0; g < 4; g++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_addr  = (g % 2 == 0) ? 32'h10 : 32'h20;
            exp_dwait = (g % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_addr  = 32'h10;
            exp_dwait = 2'b10;
`endif
            tick;
            settle;
            checks++; if (bus.ramaddr !== exp_addr) $display("FAIL rr_addr[%0d] got=%0h exp=%0h", g, bus.ramaddr, exp_addr); else passes++;
            checks++; if (bus.dwait !== exp_dwait) $display("FAIL rr_dwait[%0d] got=%b exp=%b", g, bus.dwait, exp_dwait); else passes++;
            tick;
            settle;
            checks++; if (bus.ramREN !== 1'b0) $display("FAIL rr_gap_ren[%0d] got=%0h exp=0", g, bus.ramREN); else passes++;
        end
        clr;
    endtask

    task automatic test_error;
        tick;
        bus.dREN = 2'b10; bus.daddr[63:32] = 32'h40;
        bus.ramstate = ERROR; bus.ramload = 32'hCAFE0001;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b1) $display("FAIL er_grant_ren got=%0h exp=1", bus.ramREN); else passes++;
        checks++; if (bus.ramaddr !== 32'h40) $display("FAIL er_grant_addr got=%0h exp=40", bus.ramaddr); else passes++;
        for (int c = 0; c < 2; c++) begin
            tick;
            settle;
            checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) $display("FAIL er_en[%0d] got=%b%b exp=00", c, bus.ramREN, bus.ramWEN); else passes++;
            checks++; if (bus.dwait !== 2'b10) $display("FAIL er_dwait[%0d] got=%b exp=10", c, bus.dwait); else passes++;
        end
        tick;
        bus.ramstate = FREE;
        settle;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL er_free_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.dwait !== 2'b10) $display("FAIL er_free_dwait got=%b exp=10", bus.dwait); else passes++;
        tick;
        bus.ramstate = ACCESS;
        settle;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL er_idle_ren got=%0h exp=0", bus.ramREN); else passes++;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b1) $display("FAIL er_retry_ren got=%0h exp=1", bus.ramREN); else passes++;
        checks++; if (bus.dwait !== 2'b00) $display("FAIL er_retry_dwait got=%b exp=00", bus.dwait); else passes++;
        checks++; if (bus.dload !== {32'hCAFE0001, 32'h0}) $display("FAIL er_retry_dload got=%0h exp=cafe000100000000", bus.dload); else passes++;
        tick;
        clr;
    endtask

    task automatic test_reset_mid_grant;
        tick;
        bus.dREN = 2'b01; bus.daddr = {32'h90, 32'h80}; bus.ramstate = ACCESS;
        tick;
        settle;
        checks++; if (bus.dwait !== 2'b00) $display("FAIL rm_first_dwait got=%b exp=00", bus.dwait); else passes++;
        tick;
        bus.dREN = 2'b10; bus.ramstate = BUSY; bus.ramload = 32'h0BADF00D;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b1) $display("FAIL rm_grant_ren got=%0h exp=1", bus.ramREN); else passes++;
        checks++; if (bus.ramaddr !== 32'h90) $display("FAIL rm_grant_addr got=%0h exp=90", bus.ramaddr); else passes++;
        #1;
        rst = 1'b1;
        bus.dREN = 2'b11; bus.ramstate = ACCESS;
        #1;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL rm_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.ramaddr !== 32'h0) $display("FAIL rm_addr got=%0h exp=0", bus.ramaddr); else passes++;
        checks++; if (bus.dload !== 64'h0) $display("FAIL rm_dload got=%0h exp=0", bus.dload); else passes++;
        checks++; if (bus.dwait !== 2'b11) $display("FAIL rm_dwait got=%b exp=11", bus.dwait); else passes++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick;
        settle;
        checks++; if (bus.ramaddr !== 32'h80) $display("FAIL rm_rearb_addr got=%0h exp=80", bus.ramaddr); else passes++;
        checks++; if (bus.dwait !== 2'b10) $display("FAIL rm_rearb_dwait got=%b exp=10", bus.dwait); else passes++;
        checks++; if (bus.dload !== 64'h00000000_0BADF00D) $display("FAIL rm_rearb_dload got=%0h exp=badf00d", bus.dload); else passes++;
        tick;
        clr;
    endtask

    task automatic test_abort;
        tick;
        bus.dREN = 2'b11; bus.daddr = {32'hB0, 32'hA0};
        bus.ramstate = BUSY; bus.ramload = 32'h11112222;
        tick;
        settle;
        checks++; if (bus.ramaddr !== 32'hA0) $display("FAIL ab_addr got=%0h exp=a0", bus.ramaddr); else passes++;
        checks++; if (bus.dwait !== 2'b11) $display("FAIL ab_busy_dwait got=%b exp=11", bus.dwait); else passes++;
        #1;
        bus.dREN = 2'b10;
        #1;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL ab_drop_ren got=%0h exp=0", bus.ramREN); else passes++;
        checks++; if (bus.dwait !== 2'b10) $display("FAIL ab_drop_dwait got=%b exp=10", bus.dwait); else passes++;
        checks++; if (bus.dload !== 64'h0) $display("FAIL ab_drop_dload got=%0h exp=0", bus.dload); else passes++;
        tick;
        bus.ramstate = ACCESS;
        settle;
        checks++; if (bus.ramREN !== 1'b0) $display("FAIL ab_idle_ren got=%0h exp=0", bus.ramREN); else passes++;
        tick;
        settle;
        checks++; if (bus.ramREN !== 1'b1) $display("FAIL ab_next_ren got=%0h exp=1", bus.ramREN); else passes++;
        checks++; if (bus.ramaddr !== 32'hB0) $display("FAIL ab_next_addr got=%0h exp=b0", bus.ramaddr); else passes++;
        checks++; if (bus.dwait !== 2'b00) $display("FAIL ab_next_dwait got=%b exp=00", bus.dwait); else passes++;
        checks++; if (bus.dload !== {32'h11112222, 32'h0}) $display("FAIL ab_next_dload got=%0h exp=1111222200000000", bus.dload); else passes++;
        tick;
        clr;
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_first;
        reset_dut;
        test_round_robin;
        test_error;
        test_reset_mid_grant;
        reset_dut;
        test_abort;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
